// File: rtl/riscv_pkg.sv
// Shared constants and types for the MEM stage: func3 encodings, the
// memory-handshake state and the MEM/WB bundle.
package riscv_pkg;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        misalign;
        logic [31:0] result;
        logic [31:0] mem_data;
        logic [4:0]  rd;
    } mem_wb_t;

    // EX supplies less_than already signed or unsigned to match the opcode.
    function automatic logic branch_cond(input logic [2:0] func3,
                                         input logic       zero,
                                         input logic       less_than);
        logic taken;
        case (func3)
            F3_BEQ:           taken = zero;
            F3_BNE:           taken = !zero;
            F3_BLT, F3_BLTU:  taken = less_than;
            F3_BGE, F3_BGEU:  taken = !less_than;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store byte enables / replicated data,
// alignment check, and sign/zero-extended load extraction.
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Alignment depends only on access size in func3[1:0].
    always_comb begin
        misaligned = 1'b0;
        case (func3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Store steering; replicated data lets memory ignore the lane position.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (func3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Load lane selection and extension.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_lane = rdata[7:0];
            2'b01:   byte_lane = rdata[15:8];
            2'b10:   byte_lane = rdata[23:16];
            2'b11:   byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (func3)
            F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  load_data = {24'h00_0000, byte_lane};
            F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  load_data = {16'h0000, half_lane};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: handshaked data-memory access with upstream stall,
// branch/jump redirect, and the MEM/WB pipeline register.
module mem_access_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in_mem,
    input  logic [31:0] result_in_mem,
    input  logic [31:0] rd_data_2_in_mem,
    input  logic [31:0] jal_target_in_mem,
    input  logic        zero_in_mem,
    input  logic        less_than_in_mem,
    input  logic        mem_read_in_mem,
    input  logic        mem_write_in_mem,
    input  logic        mem_to_reg_in_mem,
    input  logic        reg_write_in_mem,
    input  logic        branch_in_mem,
    input  logic        jump_in_mem,
    input  logic [4:0]  rd_in_mem,
    input  logic [2:0]  func3_in_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out_mem,
    output logic        pc_src_out_mem,
    output logic [31:0] pc_target_out_mem,
    output logic        valid_out_mem_wb,
    output logic        reg_write_out_mem_wb,
    output logic        mem_to_reg_out_mem_wb,
    output logic        misalign_out_mem_wb,
    output logic [31:0] result_out_mem_wb,
    output logic [31:0] mem_data_out_mem_wb,
    output logic [4:0]  rd_out_mem_wb
);

    mem_state_t  state;
    mem_state_t  state_next;
    mem_wb_t     mem_wb;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        misaligned;
    logic        access;
    logic        bad_access;
    logic        mem_op;

    load_store_align u_align (
        .func3      (func3_in_mem),
        .addr_lo    (result_in_mem[1:0]),
        .store_data (rd_data_2_in_mem),
        .rdata      (dmem_rdata),
        .be         (be),
        .wdata      (wdata),
        .misaligned (misaligned),
        .load_data  (load_data)
    );

    assign access     = valid_in_mem && (mem_read_in_mem || mem_write_in_mem);
    assign bad_access = access && misaligned;
    assign mem_op     = access && !misaligned;

    // Gating with rst drops an in-flight request the moment reset hits.
    assign dmem_req      = !rst && ((state == WAIT) || mem_op);
    assign dmem_we       = dmem_req && mem_write_in_mem;
    assign dmem_addr     = {result_in_mem[31:2], 2'b00};
    assign dmem_wdata    = wdata;
    assign dmem_be       = dmem_req ? be : 4'b0000;
    assign stall_out_mem = dmem_req && !dmem_ack;

    assign pc_src_out_mem = !rst && valid_in_mem && !stall_out_mem &&
                            (jump_in_mem ||
                             (branch_in_mem &&
                              branch_cond(func3_in_mem, zero_in_mem, less_than_in_mem)));
    assign pc_target_out_mem = jal_target_in_mem;

    // Handshake state: leave IDLE only when a request goes unanswered.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_op && !dmem_ack) state_next = WAIT;
                else                     state_next = IDLE;
            end
            WAIT: begin
                if (dmem_ack) state_next = IDLE;
                else          state_next = WAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // MEM/WB register; a stall inserts a bubble while data fields hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb <= '0;
        end else if (stall_out_mem) begin
            mem_wb.valid     <= 1'b0;
            mem_wb.reg_write <= 1'b0;
            mem_wb.misalign  <= 1'b0;
        end else begin
            mem_wb.valid      <= valid_in_mem;
            mem_wb.reg_write  <= valid_in_mem && reg_write_in_mem && !bad_access;
            mem_wb.mem_to_reg <= mem_to_reg_in_mem;
            mem_wb.misalign   <= bad_access;
            mem_wb.result     <= result_in_mem;
            mem_wb.rd         <= rd_in_mem;
            if (dmem_req && !mem_write_in_mem) mem_wb.mem_data <= load_data;
            else                               mem_wb.mem_data <= mem_wb.mem_data;
        end
    end

    assign valid_out_mem_wb      = mem_wb.valid;
    assign reg_write_out_mem_wb  = mem_wb.reg_write;
    assign mem_to_reg_out_mem_wb = mem_wb.mem_to_reg;
    assign misalign_out_mem_wb   = mem_wb.misalign;
    assign result_out_mem_wb     = mem_wb.result;
    assign mem_data_out_mem_wb   = mem_wb.mem_data;
    assign rd_out_mem_wb         = mem_wb.rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in_mem;
    logic [31:0] result_in_mem;
    logic [31:0] rd_data_2_in_mem;
    logic [31:0] jal_target_in_mem;
    logic        zero_in_mem;
    logic        less_than_in_mem;
    logic        mem_read_in_mem;
    logic        mem_write_in_mem;
    logic        mem_to_reg_in_mem;
    logic        reg_write_in_mem;
    logic        branch_in_mem;
    logic        jump_in_mem;
    logic [4:0]  rd_in_mem;
    logic [2:0]  func3_in_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_out_mem;
    logic        pc_src_out_mem;
    logic [31:0] pc_target_out_mem;
    logic        valid_out_mem_wb;
    logic        reg_write_out_mem_wb;
    logic        mem_to_reg_out_mem_wb;
    logic        misalign_out_mem_wb;
    logic [31:0] result_out_mem_wb;
    logic [31:0] mem_data_out_mem_wb;
    logic [4:0]  rd_out_mem_wb;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] exp_mem_data;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .valid_in_mem(valid_in_mem), .result_in_mem(result_in_mem),
        .rd_data_2_in_mem(rd_data_2_in_mem), .jal_target_in_mem(jal_target_in_mem),
        .zero_in_mem(zero_in_mem), .less_than_in_mem(less_than_in_mem),
        .mem_read_in_mem(mem_read_in_mem), .mem_write_in_mem(mem_write_in_mem),
        .mem_to_reg_in_mem(mem_to_reg_in_mem), .reg_write_in_mem(reg_write_in_mem),
        .branch_in_mem(branch_in_mem), .jump_in_mem(jump_in_mem),
        .rd_in_mem(rd_in_mem), .func3_in_mem(func3_in_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall_out_mem(stall_out_mem),
        .pc_src_out_mem(pc_src_out_mem), .pc_target_out_mem(pc_target_out_mem),
        .valid_out_mem_wb(valid_out_mem_wb), .reg_write_out_mem_wb(reg_write_out_mem_wb),
        .mem_to_reg_out_mem_wb(mem_to_reg_out_mem_wb), .misalign_out_mem_wb(misalign_out_mem_wb),
        .result_out_mem_wb(result_out_mem_wb), .mem_data_out_mem_wb(mem_data_out_mem_wb),
        .rd_out_mem_wb(rd_out_mem_wb)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (size/offset arithmetic) ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int mask;
        mask = ((1 << m_size(f3)) - 1) << (a % 4);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (m_size(f3) == 1) return (d & 32'h0000_00FF) * 32'h0101_0101;
        if (m_size(f3) == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
        int sz;
        logic [31:0] v;
        logic [31:0] top;
        sz = m_size(f3);
        if (sz == 4) return rdata;
        v   = (rdata >> (8 * (a % 4))) & ((32'h1 << (8 * sz)) - 32'h1);
        top = 32'h1 << (8 * sz - 1);
        if (!f3[2] && ((v & top) != 32'h0)) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
        return v;
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic z, input logic lt);
        if (f3 == 3'd0) return z;
        if (f3 == 3'd1) return !z;
        if (f3 == 3'd4 || f3 == 3'd6) return lt;
        if (f3 == 3'd5 || f3 == 3'd7) return !lt;
        return 1'b0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        valid_in_mem = 1'b0; result_in_mem = 32'h0; rd_data_2_in_mem = 32'h0;
        jal_target_in_mem = 32'h0; zero_in_mem = 1'b0; less_than_in_mem = 1'b0;
        mem_read_in_mem = 1'b0; mem_write_in_mem = 1'b0; mem_to_reg_in_mem = 1'b0;
        reg_write_in_mem = 1'b0; branch_in_mem = 1'b0; jump_in_mem = 1'b0;
        rd_in_mem = 5'd0; func3_in_mem = 3'd0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic drive(input logic rd_en, input logic wr_en, input logic br, input logic jp,
                         input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] target,
                         input logic [4:0] rdn, input logic z, input logic lt);
        valid_in_mem = 1'b1; mem_read_in_mem = rd_en; mem_write_in_mem = wr_en;
        branch_in_mem = br; jump_in_mem = jp; reg_write_in_mem = rw;
        mem_to_reg_in_mem = rd_en; func3_in_mem = f3; result_in_mem = addr;
        rd_data_2_in_mem = sdata; jal_target_in_mem = target; rd_in_mem = rdn;
        zero_in_mem = z; less_than_in_mem = lt;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        #1 rst = 1'b1;
        #2;
        vectors++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", dmem_req); end
        vectors++; if (stall_out_mem !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_out_mem); end
        vectors++; if (pc_src_out_mem !== 1'b0) begin errors++; $display("FAIL reset_pc_src got %b want 0", pc_src_out_mem); end
        vectors++;
        if ({valid_out_mem_wb, reg_write_out_mem_wb, mem_to_reg_out_mem_wb, misalign_out_mem_wb,
             result_out_mem_wb, mem_data_out_mem_wb, rd_out_mem_wb} !== 73'h0) begin
            errors++; $display("FAIL reset_memwb got v=%b res=%h data=%h rd=%0d want all 0",
                               valid_out_mem_wb, result_out_mem_wb, mem_data_out_mem_wb, rd_out_mem_wb);
        end
        @(posedge clk); #1 rst = 1'b0;
        exp_mem_data = 32'h0;
    endtask

    task automatic test_store();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h8765_4321, 32'h0, 5'd0, 1'b0, 1'b0);
        dmem_ack = 1'b1;
        #4;
        vectors++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL sw_req got req=%b we=%b want 1 1", dmem_req, dmem_we); end
        vectors++; if (dmem_be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b want 1111", dmem_be); end
        vectors++; if (dmem_wdata !== 32'h8765_4321) begin errors++; $display("FAIL sw_wdata got %h want 87654321", dmem_wdata); end
        vectors++; if (stall_out_mem !== 1'b0) begin errors++; $display("FAIL sw_stall got %b want 0", stall_out_mem); end
        @(posedge clk); #1;
        vectors++; if (valid_out_mem_wb !== 1'b1) begin errors++; $display("FAIL sw_valid got %b want 1", valid_out_mem_wb); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0, 5'd0, 1'b0, 1'b0);
        dmem_ack = 1'b1;
        #4;
        vectors++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", dmem_be); end
        vectors++; if (dmem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h want beefbeef", dmem_wdata); end
        vectors++; if (dmem_addr !== 32'h0000_0100) begin errors++; $display("FAIL sh_addr got %h want 00000100", dmem_addr); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_load_wait();
        logic [2:0]  f3s [2];
        logic [31:0] want [2];
        int stalls;
        f3s[0] = 3'b000; want[0] = 32'hFFFF_FF80;
        f3s[1] = 3'b100; want[1] = 32'h0000_0080;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, f3s[k], 32'h0000_0103, 32'h0, 32'h0, 5'd9, 1'b0, 1'b0);
            dmem_rdata = 32'h80FF_0000;
            stalls = 0;
            for (int c = 0; c <= 2; c++) begin
                dmem_ack = (c == 2);
                #4;
                if (stall_out_mem === 1'b1) stalls++;
                @(posedge clk); #1;
            end
            vectors++; if (stalls != 2) begin errors++; $display("FAIL lb_stall_cycles k=%0d got %0d want 2", k, stalls); end
            vectors++; if (mem_data_out_mem_wb !== want[k]) begin errors++; $display("FAIL lb_data k=%0d got %h want %h", k, mem_data_out_mem_wb, want[k]); end
            vectors++; if (valid_out_mem_wb !== 1'b1 || rd_out_mem_wb !== 5'd9) begin errors++; $display("FAIL lb_wb k=%0d got v=%b rd=%0d want 1 9", k, valid_out_mem_wb, rd_out_mem_wb); end
            exp_mem_data = want[k];
            clear_inputs();
        end
    endtask

    task automatic test_misalign();
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0);
        #4;
        vectors++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %b want 0", dmem_req); end
        @(posedge clk); #1;
        vectors++; if (misalign_out_mem_wb !== 1'b1) begin errors++; $display("FAIL mis_flag got %b want 1", misalign_out_mem_wb); end
        vectors++; if (reg_write_out_mem_wb !== 1'b0) begin errors++; $display("FAIL mis_rw got %b want 0", reg_write_out_mem_wb); end
        clear_inputs();
    endtask

    task automatic test_branch();
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h0, 32'h0, 32'h0000_0200, 5'd0, 1'b0, 1'b0);
        #4;
        vectors++; if (pc_src_out_mem !== 1'b1) begin errors++; $display("FAIL bne_pc_src got %b want 1", pc_src_out_mem); end
        vectors++; if (pc_target_out_mem !== 32'h0000_0200) begin errors++; $display("FAIL bne_target got %h want 00000200", pc_target_out_mem); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 32'h0, 32'h0, 32'h0000_0300, 5'd0, 1'b0, 1'b1);
        #4;
        vectors++; if (pc_src_out_mem !== 1'b0) begin errors++; $display("FAIL bge_pc_src got %b want 0", pc_src_out_mem); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0000_0400, 5'd1, 1'b0, 1'b0);
        #4;
        vectors++; if (pc_src_out_mem !== 1'b1) begin errors++; $display("FAIL jump_pc_src got %b want 1", pc_src_out_mem); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset_wait();
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 5'd6, 1'b0, 1'b0);
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3 rst = 1'b1;
        #1;
        vectors++; if (dmem_req !== 1'b0 || stall_out_mem !== 1'b0) begin errors++; $display("FAIL rstwait_req got req=%b stall=%b want 0 0", dmem_req, stall_out_mem); end
        vectors++;
        if ({valid_out_mem_wb, reg_write_out_mem_wb, mem_to_reg_out_mem_wb, misalign_out_mem_wb,
             result_out_mem_wb, mem_data_out_mem_wb, rd_out_mem_wb} !== 73'h0) begin
            errors++; $display("FAIL rstwait_memwb got res=%h data=%h rd=%0d want all 0",
                               result_out_mem_wb, mem_data_out_mem_wb, rd_out_mem_wb);
        end
        clear_inputs();
        exp_mem_data = 32'h0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0);
        dmem_rdata = 32'h1234_5678; dmem_ack = 1'b1;
        #4;
        vectors++; if (dmem_req !== 1'b1 || stall_out_mem !== 1'b0) begin errors++; $display("FAIL post_rst_req got req=%b stall=%b want 1 0", dmem_req, stall_out_mem); end
        @(posedge clk); #1;
        vectors++; if (mem_data_out_mem_wb !== 32'h1234_5678) begin errors++; $display("FAIL post_rst_data got %h want 12345678", mem_data_out_mem_wb); end
        exp_mem_data = 32'h1234_5678;
        clear_inputs();
    endtask

    task automatic test_random();
        logic [2:0]  load_f3 [5];
        logic [2:0]  store_f3 [3];
        int kind, lat, last;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata, target;
        logic        mis, is_mem, rw, br, jp, z, lt, exp_pc;
        logic [4:0]  rdn;
        load_f3[0] = 3'b000; load_f3[1] = 3'b001; load_f3[2] = 3'b010;
        load_f3[3] = 3'b100; load_f3[4] = 3'b101;
        store_f3[0] = 3'b000; store_f3[1] = 3'b001; store_f3[2] = 3'b010;
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 3);
            addr = $urandom; sdata = $urandom; rdata = $urandom; target = $urandom;
            rdn = 5'($urandom_range(1, 31)); rw = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1)); lt = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if (kind == 0) f3 = load_f3[$urandom_range(0, 4)];
            if (kind == 1) f3 = store_f3[$urandom_range(0, 2)];
            if (kind <= 1 && $urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
            lat = $urandom_range(0, 3);
            is_mem = (kind <= 1);
            mis = is_mem && m_mis(f3, addr);
            br = (kind == 2); jp = (kind == 2) && ($urandom_range(0, 3) == 0);
            exp_pc = jp || (br && m_taken(f3, z, lt));
            @(posedge clk); #1;
            drive(kind == 0, kind == 1, br, jp, rw, f3, addr, sdata, target, rdn, z, lt);
            dmem_rdata = rdata;
            last = (is_mem && !mis) ? lat : 0;
            for (int c = 0; c <= last; c++) begin
                if (is_mem && !mis) dmem_ack = (c == lat);
                else                dmem_ack = 1'($urandom_range(0, 1));
                #4;
                if (is_mem && !mis) begin
                    vectors++;
                    if (dmem_req !== 1'b1 || stall_out_mem !== (c != lat)) begin
                        errors++; $display("FAIL rnd_handshake it=%0d c=%0d got req=%b stall=%b want 1 %b", it, c, dmem_req, stall_out_mem, c != lat);
                    end
                end else begin
                    vectors++;
                    if (dmem_req !== 1'b0 || stall_out_mem !== 1'b0) begin
                        errors++; $display("FAIL rnd_noreq it=%0d got req=%b stall=%b want 0 0", it, dmem_req, stall_out_mem);
                    end
                end
                if (kind == 1 && !mis && c == 0) begin
                    vectors++;
                    if (dmem_we !== 1'b1 || dmem_be !== m_be(f3, addr) || dmem_wdata !== m_wdata(f3, sdata)) begin
                        errors++; $display("FAIL rnd_store it=%0d got we=%b be=%b wd=%h want 1 %b %h", it, dmem_we, dmem_be, dmem_wdata, m_be(f3, addr), m_wdata(f3, sdata));
                    end
                end
                if (is_mem && !mis && c == 0) begin
                    vectors++;
                    if (dmem_addr !== (addr & 32'hFFFF_FFFC)) begin
                        errors++; $display("FAIL rnd_addr it=%0d got %h want %h", it, dmem_addr, addr & 32'hFFFF_FFFC);
                    end
                end
                if (kind >= 2) begin
                    vectors++;
                    if (pc_src_out_mem !== exp_pc) begin
                        errors++; $display("FAIL rnd_pc_src it=%0d f3=%0d z=%b lt=%b j=%b got %b want %b", it, f3, z, lt, jp, pc_src_out_mem, exp_pc);
                    end
                end
                @(posedge clk); #1;
            end
            if (kind == 0 && !mis) exp_mem_data = m_load(f3, addr, rdata);
            vectors++;
            if (valid_out_mem_wb !== 1'b1 || result_out_mem_wb !== addr || rd_out_mem_wb !== rdn) begin
                errors++; $display("FAIL rnd_wb it=%0d got v=%b res=%h rd=%0d want 1 %h %0d", it, valid_out_mem_wb, result_out_mem_wb, rd_out_mem_wb, addr, rdn);
            end
            vectors++;
            if (reg_write_out_mem_wb !== (rw && !mis) || misalign_out_mem_wb !== mis || mem_to_reg_out_mem_wb !== (kind == 0)) begin
                errors++; $display("FAIL rnd_ctrl it=%0d got rw=%b mis=%b m2r=%b want %b %b %b", it, reg_write_out_mem_wb, misalign_out_mem_wb, mem_to_reg_out_mem_wb, rw && !mis, mis, kind == 0);
            end
            vectors++;
            if (mem_data_out_mem_wb !== exp_mem_data) begin
                errors++; $display("FAIL rnd_mem_data it=%0d f3=%0d addr=%h got %h want %h", it, f3, addr, mem_data_out_mem_wb, exp_mem_data);
            end
            clear_inputs();
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_wait();
        test_misalign();
        test_branch();
        test_reset_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
